// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin write arbiter with lock bursts and debug override for one shared register
module shared_reg_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         lock_i,
  input  logic [N*WIDTH-1:0]   wdata_i,
  input  logic                 ovr_en_i,
  input  logic [WIDTH-1:0]     ovr_val_i,
  output logic [N-1:0]         gnt_o,
  output logic                 wr_en_o,
  output logic [$clog2(N)-1:0] owner_o,
  output logic                 busy_o,
  output logic [WIDTH-1:0]     q_o
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW:0] CNT_LAST = (CW+1)'(LOCK_MAX);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_LOCK, S_OVR} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             wr_en_q, wr_en_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] stored_q, stored_d;

  logic [PW-1:0]    cur_idx;
  logic [WIDTH-1:0] cur_data;
  logic             do_write;
  logic             cur_lock;
  logic [PW-1:0]    arb_ptr;
  logic [PW:0]      scan;
  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic             rearb;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] i);
    return (i == PW'(N-1)) ? '0 : i + PW'(1);
  endfunction

  always_comb begin
    cur_idx  = '0;
    cur_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) begin
        cur_idx  = PW'(i);
        cur_data = wdata_i[i*WIDTH +: WIDTH];
      end
    end
  end

  assign do_write = |(gnt_q & req_i);
  assign cur_lock = |(gnt_q & lock_i);
  // Re-arbitration at a write edge already sees the advanced pointer.
  assign arb_ptr  = do_write ? ptr_inc(cur_idx) : ptr_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, arb_ptr} + (PW+1)'(k);
      if (scan >= (PW+1)'(N)) begin
        scan = scan - (PW+1)'(N);
      end
      if (!win_found && req_i[scan[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      wr_en_q  <= 1'b0;
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      stored_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      wr_en_q  <= wr_en_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      stored_q <= stored_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    wr_en_d  = 1'b0;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    stored_d = stored_q;
    rearb    = 1'b0;
    if (ovr_en_i) begin
      state_d = S_OVR;
      gnt_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OVR: begin
          state_d = S_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
        S_IDLE: begin
          rearb = 1'b1;
        end
        S_GRANT, S_LOCK: begin
          rearb = 1'b1;
          if (do_write) begin
            stored_d = cur_data;
            owner_d  = cur_idx;
            ptr_d    = ptr_inc(cur_idx);
            wr_en_d  = 1'b1;
            // Expiry outranks lock: the capping write lands, then the grant is released.
            if (cur_lock) begin
              if (state_q == S_GRANT && LOCK_MAX > 1) begin
                state_d = S_LOCK;
                cnt_d   = CW'(1);
                rearb   = 1'b0;
              end else if (state_q == S_LOCK && ({1'b0, cnt_q} + (CW+1)'(1)) < CNT_LAST) begin
                cnt_d = cnt_q + CW'(1);
                rearb = 1'b0;
              end
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      endcase
      if (rearb) begin
        cnt_d = '0;
        if (win_found) begin
          state_d = S_GRANT;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
        end else begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
    end
  end

  always_comb begin
    gnt_o   = gnt_q;
    wr_en_o = wr_en_q;
    owner_o = owner_q;
    busy_o  = (state_q == S_GRANT) || (state_q == S_LOCK);
    q_o     = ovr_en_i ? ovr_val_i : stored_q;
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - self-checking bench for shared_reg_arbiter
module tb_shared_reg_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int LM = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, lock;
  logic [N*W-1:0] wdata;
  logic          ovr_en;
  logic [W-1:0]  ovr_val;
  logic [N-1:0]  gnt;
  logic          wr_en;
  logic [1:0]    owner;
  logic          busy;
  logic [W-1:0]  q;

  shared_reg_arbiter #(.N(N), .WIDTH(W), .LOCK_MAX(LM)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .wdata_i(wdata),
    .ovr_en_i(ovr_en), .ovr_val_i(ovr_val), .gnt_o(gnt), .wr_en_o(wr_en),
    .owner_o(owner), .busy_o(busy), .q_o(q)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: who holds the grant, how many writes this hold has made, and the override phase.
  int       m_gnt = -1;
  int       m_burst = 0;
  int       m_ptr = 0;
  int       m_owner = 0;
  bit       m_ovr = 1'b0;
  bit       m_wr = 1'b0;
  logic [W-1:0] m_stored = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_gnt = -1; m_burst = 0; m_ptr = 0; m_owner = 0;
      m_ovr = 1'b0; m_wr = 1'b0; m_stored = '0;
    end else if (ovr_en) begin
      m_gnt = -1; m_wr = 1'b0; m_burst = 0; m_ovr = 1'b1;
    end else if (m_ovr) begin
      m_ovr = 1'b0; m_wr = 1'b0; m_gnt = -1;
    end else begin
      bit wrote;
      wrote = (m_gnt >= 0) && req[m_gnt];
      m_wr = wrote;
      if (wrote) begin
        m_stored = wdata[m_gnt*W +: W];
        m_owner = m_gnt;
        m_ptr = (m_gnt + 1) % N;
        m_burst++;
      end
      if (!(wrote && lock[m_gnt] && m_burst < LM)) begin
        m_burst = 0;
        m_gnt = -1;
        for (int k = 0; k < N; k++) begin
          if (m_gnt < 0 && req[(m_ptr + k) % N]) m_gnt = (m_ptr + k) % N;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      check("gnt", 32'(gnt), (m_gnt < 0) ? 32'd0 : (32'd1 << m_gnt));
      check("wr_en", 32'(wr_en), 32'(m_wr));
      check("owner", 32'(owner), 32'(m_owner));
      check("busy", 32'(busy), 32'(m_gnt >= 0));
      check("q", 32'(q), 32'(ovr_en ? ovr_val : m_stored));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_wd(input int i, input logic [W-1:0] v);
    wdata[i*W +: W] = v;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; lock = '0; ovr_en = 1'b0; ovr_val = '0; wdata = '0;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    tick();
    rst = 1'b1;
  endtask

  logic [3:0] exp_g [5];
  logic [3:0] exp_q [5];

  initial begin
    rst = 1'b0; req = '0; lock = '0; ovr_en = 1'b0; ovr_val = '0; wdata = '0;
    // 1: reset and single write
    set_wd(0, 4'd3);
    req = 4'b0001;
    tick(); tick();
    check("t1_rst_q", 32'(q), 32'd0);
    check("t1_rst_gnt", 32'(gnt), 32'd0);
    run = 1'b1;
    rst = 1'b1;
    tick();
    check("t1_gnt", 32'(gnt), 32'b0001);
    check("t1_wr0", 32'(wr_en), 32'd0);
    tick();
    check("t1_q", 32'(q), 32'd3);
    check("t1_wr", 32'(wr_en), 32'd1);
    check("t1_owner", 32'(owner), 32'd0);
    req = '0;
    tick();
    check("t1_idle", 32'(gnt), 32'd0);

    // 2: round-robin fairness
    do_reset();
    wdata = {4'hD, 4'hC, 4'hB, 4'hA};
    req = 4'b1111;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    tick();
    check("t2_g0", 32'(gnt), 32'(exp_g[0]));
    for (int k = 1; k < 5; k++) begin
      tick();
      check("t2_g", 32'(gnt), 32'(exp_g[k]));
      check("t2_q", 32'(q), 32'(exp_q[k-1]));
    end
    tick();
    check("t2_q4", 32'(q), 32'(exp_q[4]));
    req = '0;
    tick();

    // 3: lock burst capped at LOCK_MAX
    do_reset();
    set_wd(1, 4'd5); set_wd(2, 4'd9);
    req = 4'b0110; lock = 4'b0010;
    tick();
    check("t3_g", 32'(gnt), 32'b0010);
    for (int k = 2; k <= 9; k++) begin
      tick();
      check("t3_wr", 32'(wr_en), 32'd1);
      check("t3_own", 32'(owner), 32'd1);
      check("t3_gb", 32'(gnt), (k == 9) ? 32'b0100 : 32'b0010);
    end
    tick();
    check("t3_own2", 32'(owner), 32'd2);
    check("t3_q2", 32'(q), 32'd9);
    req = '0; lock = '0;
    tick();

    // 4: override force and release
    do_reset();
    set_wd(0, 4'd1);
    req = 4'b0001; lock = 4'b0001;
    tick();
    tick();
    check("t4_q1", 32'(q), 32'd1);
    ovr_en = 1'b1; ovr_val = 4'd2;
    #1;
    check("t4_force", 32'(q), 32'd2);
    tick();
    check("t4_gnt0", 32'(gnt), 32'd0);
    check("t4_wr0", 32'(wr_en), 32'd0);
    check("t4_busy0", 32'(busy), 32'd0);
    set_wd(0, 4'd5); lock = '0;
    tick();
    ovr_en = 1'b0;
    #1;
    check("t4_rel", 32'(q), 32'd1);
    tick();
    check("t4_idle", 32'(gnt), 32'd0);
    tick();
    check("t4_g", 32'(gnt), 32'b0001);
    check("t4_qhold", 32'(q), 32'd1);
    tick();
    check("t4_q5", 32'(q), 32'd5);
    req = '0;
    tick();

    // 5: dropped request
    do_reset();
    set_wd(2, 4'd7); set_wd(0, 4'hE);
    req = 4'b0100;
    tick();
    check("t5_g2", 32'(gnt), 32'b0100);
    req = 4'b0001;
    tick();
    check("t5_nowr", 32'(wr_en), 32'd0);
    check("t5_q", 32'(q), 32'd0);
    check("t5_g0", 32'(gnt), 32'b0001);
    tick();
    check("t5_qE", 32'(q), 32'hE);
    req = '0;
    tick();

    // 6: asynchronous reset mid-lock
    do_reset();
    set_wd(1, 4'd6); set_wd(2, 4'd8);
    req = 4'b0010; lock = 4'b0010;
    tick(); tick(); tick();
    check("t6_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_gnt", 32'(gnt), 32'd0);
    check("t6_busy0", 32'(busy), 32'd0);
    check("t6_q", 32'(q), 32'd0);
    check("t6_wr", 32'(wr_en), 32'd0);
    req = 4'b0110; lock = '0;
    tick();
    rst = 1'b1;
    tick();
    check("t6_ptr0", 32'(gnt), 32'b0010);
    tick();
    check("t6_q6", 32'(q), 32'd6);
    check("t6_own", 32'(owner), 32'd1);
    req = '0;
    tick();

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
